// File: rtl/cale_de_control_param.sv
// Control path for the LDH iterative datapath: clear, load, then step the
// datapath for a runtime-selected number of iterations, and hold the result
// until the consumer acknowledges it. An abort cancels the operation at any point.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   request a new operation (IDLE, or DONE together with ack)
//   nr_iter   in   requested iteration count, sampled with an accepted start
//   abort     in   cancel the current operation
//   ack       in   consumer accepts the result (DONE only)
//   reset_cd  out  datapath clear pulse
//   load      out  datapath operand load pulse
//   step      out  datapath iteration enable
//   iter_cnt  out  index of the current iteration
//   busy      out  operation in progress
//   readyS    out  result valid
//   aborted   out  one-cycle pulse after a cancelled operation
module cale_de_control_param #(
  parameter int unsigned X  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] nr_iter,
  input  logic          abort,
  input  logic          ack,
  output logic          reset_cd,
  output logic          load,
  output logic          step,
  output logic [CW-1:0] iter_cnt,
  output logic          busy,
  output logic          readyS,
  output logic          aborted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_req;
  logic          take_start;
  logic          aborted_d;
  logic          reset_cd_q, load_q, step_q, busy_q, readyS_q, aborted_q;

  // Effective count: zero and oversized requests both mean a full X-iteration run.
  always_comb begin
    n_req = nr_iter;
    if ((nr_iter == '0) || (nr_iter > CW'(X))) begin
      n_req = CW'(X);
    end
  end

  // Next state, count latch and abort pulse.
  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    aborted_d  = 1'b0;
    n_d        = n_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLR;
          take_start = 1'b1;
        end
      end
      S_CLR: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == (n_q - CW'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // abort outranks ack and start
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (ack) begin
          if (start) begin
            state_d    = S_CLR;
            take_start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take_start) begin
      n_d = n_req;
    end
  end

  // Iteration index: zero outside RUN/DONE, counts in RUN, frozen at n-1 in DONE.
  always_comb begin
    cnt_d = '0;
    case (state_d)
      S_RUN:   cnt_d = (state_q == S_RUN) ? (cnt_q + CW'(1)) : '0;
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  // State and Moore outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= CW'(X);
      cnt_q      <= '0;
      reset_cd_q <= 1'b0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      readyS_q   <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      reset_cd_q <= (state_d == S_CLR);
      load_q     <= (state_d == S_LOAD);
      step_q     <= (state_d == S_RUN);
      busy_q     <= (state_d == S_CLR) || (state_d == S_LOAD) || (state_d == S_RUN);
      readyS_q   <= (state_d == S_DONE);
      aborted_q  <= aborted_d;
    end
  end

  assign reset_cd = reset_cd_q;
  assign load     = load_q;
  assign step     = step_q;
  assign iter_cnt = cnt_q;
  assign busy     = busy_q;
  assign readyS   = readyS_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_cale_de_control_param.sv
// Bench for cale_de_control_param: directed scenarios followed by randomized
// operations, each cycle checked against the expected waveform derived from
// the start-to-result timing rules.
module tb_cale_de_control_param;

  localparam int X  = 8;
  localparam int CW = 4;
  localparam int VW = CW + 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] nr_iter;
  logic          abort;
  logic          ack;
  logic          reset_cd, load, step, busy, readyS, aborted;
  logic [CW-1:0] iter_cnt;

  int checks = 0;
  int errors = 0;

  cale_de_control_param #(.X(X), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nr_iter  (nr_iter),
    .abort    (abort),
    .ack      (ack),
    .reset_cd (reset_cd),
    .load     (load),
    .step     (step),
    .iter_cnt (iter_cnt),
    .busy     (busy),
    .readyS   (readyS),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [VW-1:0] ev(input bit rc, input bit ld, input bit st, input int ic,
                                       input bit bz, input bit rd, input bit ab);
    logic [CW-1:0] icv;
    icv = CW'(ic);
    return {rc, ld, st, icv, bz, rd, ab};
  endfunction

  function automatic int eff(input int nr);
    return ((nr == 0) || (nr > X)) ? X : nr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [VW-1:0] exp, input bit mask_ic, input string tag);
    logic [VW-1:0] obs, msk;
    obs = {reset_cd, load, step, iter_cnt, busy, readyS, aborted};
    msk = mask_ic ? ev(1, 1, 1, 0, 1, 1, 1) : {VW{1'b1}};
    checks++;
    assert ((obs & msk) === (exp & msk))
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (rc,ld,st,cnt,busy,rdy,ab)", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int cnt, input bit poke_ack, input bit poke_abort);
    for (int i = 0; i < cnt; i++) begin
      chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "idle");
      ack   = poke_ack;
      abort = poke_abort;
      tick();
      ack   = 1'b0;
      abort = 1'b0;
    end
    chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "idle_after");
  endtask

  task automatic launch(input int nr);
    start   = 1'b1;
    nr_iter = CW'(nr);
    tick();
    start   = 1'b0;
    nr_iter = CW'($urandom);
  endtask

  // Cycle c after the accepted start edge: 0 = clear, 1 = load, 2.. = step with index c-2.
  task automatic body(input int n, input int abort_at, input bit poke_start, input bit ack_early,
                      input bit from_done, output bit was_aborted);
    was_aborted = 1'b0;
    for (int c = 0; c < n + 2; c++) begin
      if (c == 0)      chk(ev(1, 0, 0, 0, 1, 0, 0), from_done, "clr");
      else if (c == 1) chk(ev(0, 1, 0, 0, 1, 0, 0), 0, "load");
      else             chk(ev(0, 0, 1, c - 2, 1, 0, 0), 0, "run");
      if (c == abort_at) abort = 1'b1;
      if (poke_start && (c == 3)) begin
        start   = 1'b1;
        nr_iter = CW'($urandom);
      end
      if (ack_early && (c == n + 1)) ack = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      ack   = 1'b0;
      if (c == abort_at) begin
        chk(ev(0, 0, 0, 0, 0, 0, 1), 0, "abort_pulse");
        tick();
        chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "abort_idle");
        was_aborted = 1'b1;
        return;
      end
    end
  endtask

  // mode 0: ack -> idle, 1: ack+start back-to-back, 2: abort (with ack and start).
  task automatic done_phase(input int n, input int hold, input int mode, input int new_nr);
    for (int h = 0; h < hold; h++) begin
      chk(ev(0, 0, 0, n - 1, 0, 1, 0), 0, "done_hold");
      start = (h % 2) == 0;
      tick();
      start = 1'b0;
    end
    chk(ev(0, 0, 0, n - 1, 0, 1, 0), 0, "done");
    ack = 1'b1;
    if (mode == 1) begin
      start   = 1'b1;
      nr_iter = CW'(new_nr);
    end else if (mode == 2) begin
      start = 1'b1;
      abort = 1'b1;
    end
    tick();
    ack   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    nr_iter = CW'($urandom);
    if (mode == 0) begin
      chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "ack_idle");
    end else if (mode == 2) begin
      chk(ev(0, 0, 0, 0, 0, 0, 1), 0, "done_abort_pulse");
      tick();
      chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "done_abort_idle");
    end
  endtask

  initial begin
    bit ab;
    reset   = 1'b0;
    start   = 1'b0;
    nr_iter = '0;
    abort   = 1'b0;
    ack     = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "reset");
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle_cycles(1, 0, 0);

    // Default run
    launch(5);
    body(5, -1, 0, 0, 0, ab);
    done_phase(5, 2, 0, 0);

    // Zero, saturated and single-iteration counts
    launch(0);
    body(eff(0), -1, 0, 0, 0, ab);
    done_phase(eff(0), 0, 0, 0);
    launch(15);
    body(eff(15), -1, 0, 0, 0, ab);
    done_phase(eff(15), 0, 0, 0);
    launch(1);
    body(1, -1, 0, 0, 0, ab);
    done_phase(1, 1, 0, 0);

    // Abort on the third step cycle, then a normal run
    launch(6);
    body(6, 4, 0, 0, 0, ab);
    launch(4);
    body(4, -1, 0, 0, 0, ab);
    done_phase(4, 0, 0, 0);

    // Ignored inputs: start in RUN, ack/abort in IDLE, long hold in DONE
    launch(5);
    body(5, -1, 1, 0, 0, ab);
    done_phase(5, 10, 0, 0);
    idle_cycles(3, 1, 0);
    idle_cycles(3, 0, 1);

    // ack on the edge entering DONE is not seen
    launch(3);
    body(3, -1, 0, 1, 0, ab);
    done_phase(3, 0, 0, 0);

    // Back-to-back
    launch(4);
    body(4, -1, 0, 0, 0, ab);
    done_phase(4, 1, 1, 3);
    body(3, -1, 0, 0, 1, ab);
    done_phase(3, 0, 0, 0);

    // Abort in DONE beats ack and start
    launch(2);
    body(2, -1, 0, 0, 0, ab);
    done_phase(2, 1, 2, 0);

    // Asynchronous reset in the middle of RUN
    launch(8);
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    chk(ev(0, 0, 0, 0, 0, 0, 0), 0, "async_reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle_cycles(2, 0, 0);

    // Randomized operations
    for (int r = 0; r < 40; r++) begin
      int nr, n, abort_at, mode, nr2, n2;
      nr = int'($urandom_range(0, 15));
      n  = eff(nr);
      abort_at = (($urandom % 4) == 0) ? int'($urandom_range(0, n + 1)) : -1;
      launch(nr);
      body(n, abort_at, (n >= 2) && (($urandom % 3) == 0), ($urandom % 4) == 0, 0, ab);
      if (!ab) begin
        mode = int'($urandom_range(0, 2));
        nr2  = int'($urandom_range(0, 15));
        done_phase(n, int'($urandom_range(0, 3)), mode, nr2);
        if (mode == 1) begin
          n2 = eff(nr2);
          body(n2, -1, 0, 0, 1, ab);
          done_phase(n2, int'($urandom_range(0, 2)), 0, 0);
        end
      end
      if (($urandom % 3) == 0) idle_cycles(int'($urandom_range(1, 3)), $urandom % 2, $urandom % 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cale_de_control_param.md
# cale_de_control_param

Parametrised control path for the LDH iterative datapath. It supersedes the fixed-width control unit. It adds a runtime iteration count, a step enable, an abort path, and a ready/ack result handshake so the consumer can hold the result. It sits between the top-level sequencer, which drives `start`/`abort`/`ack`, and the datapath, which consumes `reset_cd`/`load`/`step`.

## Interface
- `X`, default 8: maximum iteration count, equal to the datapath operand width; must be ≥ 1.
- `CW`, default 4: counter width; must satisfy 2^CW > X.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request a new operation; sampled only in IDLE, or in DONE together with `ack`.
- `nr_iter`  in  CW  requested iteration count; sampled with `start`.
- `abort`  in  1  cancel the current operation.
- `ack`  in  1  consumer accepts the result; meaningful only in DONE.
- `reset_cd`  out  1  synchronous clear pulse to the datapath.
- `load`  out  1  operand load pulse to the datapath.
- `step`  out  1  datapath iteration enable.
- `iter_cnt`  out  CW  index of the current iteration.
- `busy`  out  1  operation in progress.
- `readyS`  out  1  result valid.
- `aborted`  out  1  one-cycle pulse marking a cancelled operation.

## Operation
- FSM states: IDLE, CLR, LOAD, RUN, DONE. All outputs are registered and decoded as Moore outputs from the state.
- Effective count `n` is latched on an accepted `start`:
  - `nr_iter == 0` gives n = X.
  - `nr_iter > X` gives n = X (saturate).
  - Otherwise n = `nr_iter`.
  - `n` is held until the next accepted start.
- IDLE: all outputs 0. `start=1` → CLR.
- CLR: `reset_cd=1`, `busy=1`. Go to LOAD.
- LOAD: `load=1`, `busy=1`, `iter_cnt` cleared to 0. Go to RUN.
- RUN: `step=1`, `busy=1`. `iter_cnt` increments each cycle. On the cycle where `iter_cnt == n-1`, the next state is DONE. `iter_cnt` holds n-1 in DONE and never wraps.
- DONE: `readyS=1`, `busy=0`, held until `ack=1`.
  - `ack=1` with `start=0` → IDLE.
  - `ack=1` with `start=1` → CLR, a back-to-back operation; `n` is re-latched.
- `start` in CLR, LOAD or RUN is ignored; it is not queued.
- `start` in DONE without `ack` is ignored.
- `abort=1` in CLR, LOAD or RUN:
  - Next state IDLE, `aborted=1` for exactly that one next cycle.
  - `iter_cnt` cleared.
  - No `readyS` is produced.
- `abort=1` in DONE:
  - Next state IDLE, `readyS` drops, `aborted=1` for one cycle.
  - `abort` wins over `ack` and `start`.
- `abort` in IDLE has no effect and produces no pulse.
- Unused state encodings recover to IDLE on the next edge.

## Timing
- Reset value of every output: `reset_cd=0`, `load=0`, `step=0`, `iter_cnt=0`, `busy=0`, `readyS=0`, `aborted=0`; state IDLE.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- Taking `start` sampled at edge k:
  - `reset_cd` is high during cycle k+1.
  - `load` is high during k+2.
  - `step` is high during k+3 … k+2+n, with `iter_cnt` = 0 … n-1.
  - `readyS` rises at k+3+n.
- `busy` is high from k+1 through k+2+n, i.e. n+2 cycles.
- Minimum start-to-readyS latency is n+3 cycles.
- Back-to-back operation: `ack` and `start` sampled at edge m give `readyS=0` and `reset_cd=1` during cycle m+1, with no idle bubble.
- `ack` sampled in the same edge that enters DONE is not seen. `readyS` is high for at least one cycle.

## Test plan
- Reset, default run: hold `reset=0` for 3 cycles and check all outputs are 0. Release, then pulse `start` with `nr_iter=5`. Expect:
  - `reset_cd` at k+1 and `load` at k+2.
  - `step` at k+3 … k+7 with `iter_cnt` 0..4.
  - `readyS` from k+8 until `ack`, then IDLE.
- Saturation and zero count: `nr_iter=0` gives 8 step cycles. `nr_iter=15` gives 8 step cycles (X=8). `nr_iter=1` gives a single step cycle with `iter_cnt=0`.
- Abort: `abort=1` on the third RUN cycle. Expect `aborted=1` for one cycle, then IDLE, `busy=0`, `iter_cnt=0`, and no `readyS`. A subsequent `start` runs normally.
- Ignored inputs:
  - `start` pulsed during RUN gives no restart and no change to the cycle count.
  - `ack` pulsed in IDLE has no effect.
  - `readyS` held for 10 cycles without `ack` stays high.
- Back-to-back: `ack=1` and `start=1` with `nr_iter=3` in DONE. Expect `reset_cd` the next cycle and 3 step cycles.
- Async reset in RUN: drop `reset` mid-cycle. All outputs clear before the next `clk` edge. After release the FSM stays in IDLE until `start`.
